// File: rtl/i2c_init_sequencer.sv
// Walks a register/value table and issues one I2C write per entry, with NACK retries and inter-transaction delay.
// Optional read-back verification of each write is enabled by defining I2C_INIT_SEQUENCER_READBACK_EN.
module i2c_init_sequencer #(
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         NUM_ENTRIES = 32,
    parameter int         INTER_DELAY = 100_000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [5:0]  tbl_idx,
    input  logic [15:0] tbl_data,
    output logic        m_req,
    output logic        m_rw,
    output logic [6:0]  m_addr,
    output logic [7:0]  m_reg,
    output logic [7:0]  m_wdata,
    input  logic        m_done,
    input  logic        m_nack,
    input  logic [7:0]  m_rdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  err_idx
);

    localparam int DLY_W = (INTER_DELAY < 1) ? 1 : $clog2(INTER_DELAY + 1);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        DELAY,
        FINISH,
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
        RB_ISSUE,
        RB_WAIT,
`endif
        FAIL
    } state_t;

    state_t             state, state_nxt;
    logic [5:0]         tbl_idx_nxt;
    logic [5:0]         err_idx_nxt;
    logic [7:0]         m_reg_nxt, m_wdata_nxt;
    logic               m_req_nxt;
    logic               busy_nxt, done_nxt, error_nxt;
    logic [DLY_W-1:0]   dly_cnt, dly_nxt;
    logic [RTY_W-1:0]   rty_cnt, rty_nxt;
    logic               reissue, reissue_nxt;

    assign m_addr = DEV_ADDR;

`ifdef I2C_INIT_SEQUENCER_READBACK_EN
    // rd_phase remembers whether a pending reissue repeats the write or the read-back.
    logic rd_phase, rd_phase_nxt;
    logic m_rw_q, m_rw_nxt;
    assign m_rw = m_rw_q;
`else
    logic rdata_unused;
    assign m_rw         = 1'b0;
    assign rdata_unused = ^m_rdata;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tbl_idx <= '0;
            err_idx <= '0;
            m_reg   <= '0;
            m_wdata <= '0;
            m_req   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            dly_cnt <= '0;
            rty_cnt <= '0;
            reissue <= 1'b0;
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
            rd_phase <= 1'b0;
            m_rw_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            tbl_idx <= tbl_idx_nxt;
            err_idx <= err_idx_nxt;
            m_reg   <= m_reg_nxt;
            m_wdata <= m_wdata_nxt;
            m_req   <= m_req_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            error   <= error_nxt;
            dly_cnt <= dly_nxt;
            rty_cnt <= rty_nxt;
            reissue <= reissue_nxt;
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
            rd_phase <= rd_phase_nxt;
            m_rw_q   <= m_rw_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        tbl_idx_nxt = tbl_idx;
        err_idx_nxt = err_idx;
        m_reg_nxt   = m_reg;
        m_wdata_nxt = m_wdata;
        busy_nxt    = busy;
        done_nxt    = done;
        error_nxt   = error;
        dly_nxt     = dly_cnt;
        rty_nxt     = rty_cnt;
        reissue_nxt = reissue;
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
        rd_phase_nxt = rd_phase;
        m_rw_nxt     = m_rw_q;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    done_nxt    = 1'b0;
                    error_nxt   = 1'b0;
                    rty_nxt     = '0;
                    dly_nxt     = '0;
                    reissue_nxt = 1'b0;
                    tbl_idx_nxt = '0;
                    busy_nxt    = 1'b1;
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
                    rd_phase_nxt = 1'b0;
`endif
                    state_nxt   = FETCH;
                end
            end
            FETCH: state_nxt = LOAD;
            LOAD: begin
                m_reg_nxt   = tbl_data[15:8];
                m_wdata_nxt = tbl_data[7:0];
                state_nxt   = (tbl_data[15:8] == 8'hFF) ? FINISH : ISSUE;
            end
            ISSUE: begin
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
                m_rw_nxt     = 1'b0;
                rd_phase_nxt = 1'b0;
`endif
                state_nxt = WAIT;
            end
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
            RB_ISSUE: begin
                m_rw_nxt     = 1'b1;
                rd_phase_nxt = 1'b1;
                state_nxt    = RB_WAIT;
            end
            WAIT, RB_WAIT: begin
`else
            WAIT: begin
`endif
                // m_done only counts while a request is actually outstanding.
                if (m_done && m_req) begin
                    if (m_nack) begin
                        if (int'(rty_cnt) < MAX_RETRY) begin
                            rty_nxt     = rty_cnt + RTY_W'(1);
                            reissue_nxt = 1'b1;
                            state_nxt   = DELAY;
                        end else begin
                            err_idx_nxt = tbl_idx;
                            state_nxt   = FAIL;
                        end
                    end else begin
                        rty_nxt = '0;
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
                        if (state == WAIT) begin
                            state_nxt = RB_ISSUE;
                        end else if (m_rdata != m_wdata) begin
                            err_idx_nxt = tbl_idx;
                            state_nxt   = FAIL;
                        end else begin
                            state_nxt = DELAY;
                        end
`else
                        state_nxt = DELAY;
`endif
                    end
                end
            end
            DELAY: begin
                if (int'(dly_cnt) + 1 >= INTER_DELAY) begin
                    dly_nxt = '0;
                    if (reissue) begin
                        reissue_nxt = 1'b0;
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
                        state_nxt   = rd_phase ? RB_ISSUE : ISSUE;
`else
                        state_nxt   = ISSUE;
`endif
                    end else begin
                        tbl_idx_nxt = tbl_idx + 6'd1;
                        state_nxt   = (int'(tbl_idx) + 1 < NUM_ENTRIES) ? FETCH : FINISH;
                    end
                end else begin
                    dly_nxt = dly_cnt + DLY_W'(1);
                end
            end
            FINISH: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            FAIL: begin
                error_nxt = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

`ifdef I2C_INIT_SEQUENCER_READBACK_EN
        m_req_nxt = (state_nxt == WAIT) || (state_nxt == RB_WAIT);
`else
        m_req_nxt = (state_nxt == WAIT);
`endif
    end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench for i2c_init_sequencer: a master model answers requests, a monitor checks each request and posted status.
module tb_i2c_init_sequencer;

    localparam int         INTER_DELAY = 5;
    localparam int         NUM_ENTRIES = 4;
    localparam int         MAX_RETRY   = 3;
    localparam logic [6:0] DEV_ADDR    = 7'h39;
    localparam int         MLAT        = 2;
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start;
    logic [5:0]  tbl_idx, err_idx;
    logic [15:0] tbl_data;
    logic        m_req, m_rw, m_done, m_nack;
    logic [6:0]  m_addr;
    logic [7:0]  m_reg, m_wdata, m_rdata;
    logic        busy, done, error;

    always #5 clk = ~clk;

    i2c_init_sequencer #(
        .DEV_ADDR(DEV_ADDR), .NUM_ENTRIES(NUM_ENTRIES),
        .INTER_DELAY(INTER_DELAY), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
        .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr), .m_reg(m_reg), .m_wdata(m_wdata),
        .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx)
    );

    // Table ROM with one clock of read latency.
    logic [15:0] tbl [0:63];
    always @(posedge clk) tbl_data <= tbl[tbl_idx];

    typedef struct packed {
        logic       rw;
        logic [7:0] ra;
        logic [7:0] wd;
    } req_t;

    // Single-writer ring buffers: main writes, monitor reads.
    req_t        exp_arr [0:255];
    int          exp_wr = 0;
    string       chk_name [0:255];
    logic [31:0] chk_act [0:255];
    logic [31:0] chk_exp [0:255];
    int          chk_wr = 0;
    logic        nack_plan [0:255];
    logic        rd_bad = 1'b0;
    logic [7:0]  rd_val = 8'h00;
    int          spur_req = 0;
    logic        main_done = 1'b0;

    int          req_seen = 0;
    int          spur_ack = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
        chk_name[chk_wr] = n;
        chk_act[chk_wr]  = a;
        chk_exp[chk_wr]  = e;
        chk_wr++;
    endtask

    task automatic push_w(input logic rw, input logic [7:0] ra, input logic [7:0] wd);
        exp_arr[exp_wr] = '{rw: rw, ra: ra, wd: wd};
        exp_wr++;
    endtask

    task automatic push_ok(input logic [7:0] ra, input logic [7:0] wd);
        push_w(1'b0, ra, wd);
        if (RB != 0) push_w(1'b1, ra, wd);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) post("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_reqs(input int target, input int bound);
        int n = 0;
        while (req_seen < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (req_seen < target) post("req_timeout", 32'(req_seen), 32'(target));
    endtask

    // Master model: answers each request after MLAT clocks, nack pattern indexed by request number.
    initial begin
        int mst_n = 0;
        m_done  = 1'b0;
        m_nack  = 1'b0;
        m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (m_req && !reset) begin
                repeat (MLAT) @(negedge clk);
                m_done  = 1'b1;
                m_nack  = nack_plan[mst_n];
                m_rdata = rd_bad ? rd_val : m_wdata;
                mst_n++;
                @(negedge clk);
                m_done = 1'b0;
                m_nack = 1'b0;
            end else if (spur_req != spur_ack) begin
                m_done   = 1'b1;
                m_nack   = 1'b1;
                spur_ack = spur_req;
                @(negedge clk);
                m_done = 1'b0;
                m_nack = 1'b0;
            end
        end
    end

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Monitor: pops expected requests on each m_req rise and drains posted status checks.
    initial begin
        int   exp_rd = 0;
        int   chk_rd = 0;
        int   low_cnt = 0;
        logic have_fall = 1'b0;
        logic prev_req = 1'b0;
        logic unstable = 1'b0;
        req_t cap, e;
        forever begin
            @(negedge clk);
            while (chk_rd < chk_wr) begin
                cmp(chk_name[chk_rd], chk_act[chk_rd], chk_exp[chk_rd]);
                chk_rd++;
            end
            if (m_req === 1'b1 && !prev_req) begin
                req_seen++;
                if (exp_rd < exp_wr) begin
                    e = exp_arr[exp_rd];
                    exp_rd++;
                    cmp("req_rw", 32'(m_rw), 32'(e.rw));
                    cmp("req_reg", 32'(m_reg), 32'(e.ra));
                    cmp("req_wdata", 32'(m_wdata), 32'(e.wd));
                    cmp("req_addr", 32'(m_addr), 32'(DEV_ADDR));
                end else begin
                    cmp("unexpected_req", 32'(req_seen), 32'(exp_wr));
                end
                if (!m_rw && have_fall) cmp("gap_short", 32'(low_cnt < INTER_DELAY), 32'd0);
                cap      = '{rw: m_rw, ra: m_reg, wd: m_wdata};
                unstable = 1'b0;
            end else if (m_req === 1'b1) begin
                if ({m_rw, m_reg, m_wdata} !== cap) unstable = 1'b1;
            end
            if (m_req !== 1'b1 && prev_req) begin
                cmp("req_unstable", 32'(unstable), 32'd0);
                have_fall = 1'b1;
                low_cnt   = 1;
            end else if (m_req !== 1'b1) begin
                low_cnt++;
            end
            prev_req = (m_req === 1'b1);
            if (main_done && chk_rd == chk_wr) break;
        end
        cmp("reqs_consumed", 32'(exp_rd), 32'(exp_wr));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) tbl[i] = 16'h0000;
        for (int i = 0; i < 256; i++) nack_plan[i] = 1'b0;
        repeat (3) @(negedge clk);
        post("rst_m_req", 32'(m_req), 32'd0);
        post("rst_busy", 32'(busy), 32'd0);
        post("rst_done", 32'(done), 32'd0);
        post("rst_error", 32'(error), 32'd0);
        post("rst_tbl_idx", 32'(tbl_idx), 32'd0);
        post("rst_err_idx", 32'(err_idx), 32'd0);
        post("rst_m_reg", 32'(m_reg), 32'd0);
        post("rst_m_wdata", 32'(m_wdata), 32'd0);
        post("rst_m_rw", 32'(m_rw), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Two writes then end marker; a second start mid-run must be ignored.
        tbl[0] = 16'h4110; tbl[1] = 16'h9803; tbl[2] = 16'hFF55; tbl[3] = 16'h7777;
        push_ok(8'h41, 8'h10);
        push_ok(8'h98, 8'h03);
        base = req_seen;
        pulse_start();
        post("t1_busy", 32'(busy), 32'd1);
        wait_reqs(base + 1, 200);
        pulse_start();
        wait_idle(2000);
        post("t1_done", 32'(done), 32'd1);
        post("t1_error", 32'(error), 32'd0);
        post("t1_tbl_idx", 32'(tbl_idx), 32'd2);

        // Entry 0 NACKed twice then ACKed.
        tbl[0] = 16'h4110; tbl[1] = 16'h9803; tbl[2] = 16'h2255; tbl[3] = 16'hFF00;
        base = req_seen;
        nack_plan[base] = 1'b1;
        nack_plan[base + 1] = 1'b1;
        push_w(1'b0, 8'h41, 8'h10);
        push_w(1'b0, 8'h41, 8'h10);
        push_ok(8'h41, 8'h10);
        push_ok(8'h98, 8'h03);
        push_ok(8'h22, 8'h55);
        pulse_start();
        wait_idle(2000);
        post("t2_done", 32'(done), 32'd1);
        post("t2_error", 32'(error), 32'd0);

        // Entry 1 NACKed four times: retries exhausted.
        tbl[0] = 16'h0101; tbl[1] = 16'h0202; tbl[2] = 16'hFF00; tbl[3] = 16'h0303;
        base = req_seen + 1 + RB;
        for (int k = 0; k < 4; k++) nack_plan[base + k] = 1'b1;
        push_ok(8'h01, 8'h01);
        for (int k = 0; k < 4; k++) push_w(1'b0, 8'h02, 8'h02);
        pulse_start();
        wait_idle(2000);
        post("t3_error", 32'(error), 32'd1);
        post("t3_err_idx", 32'(err_idx), 32'd1);
        post("t3_done", 32'(done), 32'd0);
        post("t3_busy", 32'(busy), 32'd0);

        // No end marker: runs to NUM_ENTRIES; a stray m_done during the delay is ignored.
        tbl[0] = 16'h0A01; tbl[1] = 16'h0B02; tbl[2] = 16'h0C03; tbl[3] = 16'h0D04;
        push_ok(8'h0A, 8'h01); push_ok(8'h0B, 8'h02);
        push_ok(8'h0C, 8'h03); push_ok(8'h0D, 8'h04);
        base = req_seen;
        pulse_start();
        wait_reqs(base + 1, 200);
        for (int n = 0; n < 50 && m_req; n++) @(negedge clk);
        spur_req++;
        wait_idle(2000);
        post("t4_done", 32'(done), 32'd1);
        post("t4_error", 32'(error), 32'd0);
        post("t4_tbl_idx", 32'(tbl_idx), 32'd4);

        // Reset while entry 3 is being requested.
        push_ok(8'h0A, 8'h01); push_ok(8'h0B, 8'h02); push_ok(8'h0C, 8'h03);
        push_w(1'b0, 8'h0D, 8'h04);
        base = req_seen;
        pulse_start();
        wait_reqs(base + 4 + 3 * RB, 500);
        post("t5_req_before_rst", 32'(m_req), 32'd1);
        post("t5_idx_before_rst", 32'(tbl_idx), 32'd3);
        reset = 1'b1;
        #1;
        post("t5_m_req", 32'(m_req), 32'd0);
        post("t5_busy", 32'(busy), 32'd0);
        post("t5_tbl_idx", 32'(tbl_idx), 32'd0);
        post("t5_m_reg", 32'(m_reg), 32'd0);
        post("t5_m_wdata", 32'(m_wdata), 32'd0);
        post("t5_done", 32'(done), 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (10) @(negedge clk);
        post("t5_no_resume", 32'(busy), 32'd0);
        push_ok(8'h0A, 8'h01); push_ok(8'h0B, 8'h02);
        push_ok(8'h0C, 8'h03); push_ok(8'h0D, 8'h04);
        pulse_start();
        wait_idle(2000);
        post("t5_restart_done", 32'(done), 32'd1);

`ifdef I2C_INIT_SEQUENCER_READBACK_EN
        // Read-back returns the wrong value for entry 0.
        tbl[0] = 16'h4110; tbl[1] = 16'hFF00;
        rd_bad = 1'b1;
        rd_val = 8'h11;
        push_w(1'b0, 8'h41, 8'h10);
        push_w(1'b1, 8'h41, 8'h10);
        pulse_start();
        wait_idle(2000);
        post("t6_error", 32'(error), 32'd1);
        post("t6_err_idx", 32'(err_idx), 32'd0);
        post("t6_done", 32'(done), 32'd0);
        rd_bad = 1'b0;
`endif

        repeat (4) @(negedge clk);
        main_done = 1'b1;
    end

endmodule

// File: doc/i2c_init_sequencer.md
I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h39: 7-bit I2C device address used for every transaction.
REQ-002 SHALL have parameter NUM_ENTRIES, default 32: table depth; entries 0..NUM_ENTRIES-1 are walked in order.
REQ-003 SHALL have parameter INTER_DELAY, default 100_000: idle clocks between consecutive transactions.
REQ-004 SHALL have parameter MAX_RETRY, default 3: reissues allowed per entry after NACK.
REQ-005 SHALL have ports (clock and reset first):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a sequence run.
- tbl_idx  out  6  table read index.
- tbl_data  in  16  table entry {reg_addr[15:8], wdata[7:0]}, valid one clock after tbl_idx changes.
- m_req  out  1  transaction request to the I2C master.
- m_rw  out  1  1 = read, 0 = write.
- m_addr  out  7  device address; always DEV_ADDR.
- m_reg  out  8  register address.
- m_wdata  out  8  write data.
- m_done  in  1  single-cycle pulse from the master: transaction finished.
- m_nack  in  1  valid with m_done; 1 = slave NACKed.
- m_rdata  in  8  read data, valid with m_done.
- busy  out  1  high from start acceptance until DONE or FAIL.
- done  out  1  sticky; sequence completed without error.
- error  out  1  sticky; sequence aborted.
- err_idx  out  6  index of the failing entry; valid while error = 1.

Function
REQ-006 SHALL implement states IDLE, FETCH, LOAD, ISSUE, WAIT, DELAY, FINISH, FAIL (plus RB_ISSUE and RB_WAIT per REQ-019).
REQ-007 IDLE: when start = 1, clear done, error and the retry count; set tbl_idx = 0; go to FETCH. start SHALL be ignored in every other state.
REQ-008 FETCH: wait one clock for table latency, then go to LOAD.
REQ-009 LOAD: register tbl_data into the m_reg/m_wdata holding registers.
- If reg_addr == 8'hFF (end marker), go to FINISH.
- Otherwise go to ISSUE.
REQ-010 ISSUE: assert m_req with m_rw = 0; go to WAIT.
REQ-011 m_req and m_rw/m_addr/m_reg/m_wdata SHALL stay stable from ISSUE until the clock m_done is sampled; m_req SHALL drop on the clock after m_done.
REQ-012 WAIT, m_done with m_nack = 0: clear the retry count; go to DELAY.
REQ-013 WAIT, m_done with m_nack = 1:
- If the retry count < MAX_RETRY: increment it, return to DELAY, then reissue the same entry.
- Otherwise: set err_idx = tbl_idx; go to FAIL.
REQ-014 DELAY: count INTER_DELAY clocks with m_req = 0, then advance.
- To a reissue of the same entry if one is pending.
- Else increment tbl_idx; go to FETCH if tbl_idx < NUM_ENTRIES, otherwise go to FINISH.
REQ-015 FINISH: set done = 1, busy = 0; go to IDLE.
REQ-016 FAIL: set error = 1, busy = 0; go to IDLE.
REQ-017 The delay counter SHALL be at least ceil(log2(INTER_DELAY+1)) bits wide. The retry counter SHALL saturate and never wrap.
REQ-018 m_done arriving while m_req = 0 SHALL be ignored.

Reset
REQ-020 reset SHALL asynchronously force state IDLE and set all of the following to 0: m_req, m_rw, m_reg, m_wdata, tbl_idx, busy, done, error, err_idx, and all counters.
REQ-021 Reset asserted mid-transaction SHALL drop m_req immediately. The interrupted run SHALL NOT resume; a new start pulse is required.

Configuration
REQ-019 When macro I2C_INIT_SEQUENCER_READBACK_EN is defined, each successful write SHALL be followed by a read-back:
- RB_ISSUE: m_req with m_rw = 1, same m_reg.
- RB_WAIT: waits for m_done.
- NACK: handled with retries per REQ-013.
- m_rdata != m_wdata: err_idx = tbl_idx; go to FAIL.
- Match: go to DELAY.
REQ-022 When I2C_INIT_SEQUENCER_READBACK_EN is undefined:
- RB_ISSUE/RB_WAIT SHALL be absent.
- m_rw SHALL be constant 0.
- m_rdata SHALL be unused.

Verification
REQ-023 Table {0x41,0x10},{0x98,0x03},{0xFF,xx}; start; master always ACKs -> exactly two write transactions, in order (0x41/0x10, then 0x98/0x03), separated by INTER_DELAY idle clocks; done = 1; tbl_idx stops at 2.
REQ-024 Entry 0 NACKed twice, then ACKed (MAX_RETRY = 3) -> three requests for entry 0, then entry 1 proceeds; error = 0.
REQ-025 Entry 1 NACKed 4 times -> 4 requests for entry 1; error = 1; err_idx = 1; done = 0; busy = 0.
REQ-026 Reset pulsed while m_req = 1 on entry 3 -> m_req = 0 within the same clock; all outputs are 0; the next start restarts at tbl_idx = 0.
REQ-027 No 0xFF marker in the table, NUM_ENTRIES = 4 -> 4 writes, then done = 1.
REQ-028 READBACK_EN defined; m_rdata = 0x11 for write data 0x10 at entry 0 -> one write, one read to 0x41, then error = 1, err_idx = 0.
